// File: rtl/vend_checkout.sv
// Vending checkout: debounced coin keys, item totals, confirm/cancel FSM,
// timed dispense and BCD totals. Define SEG7_EN to add the registered 7-seg output.
module vend_checkout #(
    parameter int                      NUM_KEYS    = 3,
    parameter int                      NUM_ITEMS   = 4,
    parameter int                      DIGITS      = 2,
    parameter int                      DEB_CYC     = 1000000,
    parameter int                      DISP_CYC    = 50000000,
    parameter logic [8*NUM_KEYS-1:0]   PAY_VALS    = {8'd5, 8'd1, 8'd10},
    parameter logic [8*NUM_ITEMS-1:0]  ITEM_PRICES = {8'd10, 8'd8, 8'd5, 8'd3}
) (
    input  logic                         clock,
    input  logic                         clr,
    input  logic [NUM_KEYS-1:0]          key,
    input  logic                         item_vld,
    input  logic [$clog2(NUM_ITEMS)-1:0] item_id,
    input  logic                         confirm,
    input  logic                         cancel,
    output logic [4*DIGITS-1:0]          pay_bcd,
    output logic [4*DIGITS-1:0]          item_bcd,
    output logic [4*DIGITS-1:0]          change_bcd,
    output logic                         ovf,
    output logic                         short,
    output logic                         dispense,
    output logic                         refund,
    output logic [1:0]                   state
`ifdef SEG7_EN
    ,
    output logic [7*3*DIGITS-1:0]        seg
`endif
);

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    localparam int MAX    = pow10(DIGITS) - 1;
    localparam int TOT_W  = $clog2(MAX + 1);
    localparam int SUM_W  = TOT_W + 9;
    localparam int CNT_W  = $clog2(DEB_CYC + 1);
    localparam int DISP_W = $clog2(DISP_CYC + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2
    } st_t;

    // Saturating accumulate; MSB of the result flags that the clamp engaged.
    function automatic logic [TOT_W:0] sat_add(input logic [TOT_W-1:0] a, input logic [7:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(MAX)) return {1'b1, TOT_W'(MAX)};
        return {1'b0, s[TOT_W-1:0]};
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input logic [TOT_W-1:0] v);
        logic [4*DIGITS-1:0] r;
        int unsigned         x;
        r = '0;
        x = 32'(v);
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    st_t                 st, nxt;
    logic [NUM_KEYS-1:0] samp, comm, pend, pend_nxt, fall, coin_oh;
    logic [CNT_W-1:0]    cnt [NUM_KEYS];
    logic [TOT_W-1:0]    pay, item, chg;
    logic                pay_sat, item_sat;
    logic [DISP_W-1:0]   disp_cnt;
    logic signed [TOT_W:0] diff;
    logic                coin_hit, id_ok;
    logic [7:0]          coin_val, price;
    logic [TOT_W:0]      pay_sum, item_sum;
    logic                cancel_act, confirm_act, item_act, coin_act;

    assign diff     = $signed({1'b0, pay}) - $signed({1'b0, item});
    assign short    = (diff < 0);
    assign dispense = (st == DISPENSE);
    assign state    = st;
    assign id_ok    = (int'(item_id) < NUM_ITEMS);
    assign price    = id_ok ? ITEM_PRICES[8*item_id +: 8] : 8'd0;
    assign pay_sum  = sat_add(pay, coin_val);
    assign item_sum = sat_add(item, price);

    // Per-key debounce commit and lowest-index coin selection
    always_comb begin
        coin_hit = 1'b0;
        coin_oh  = '0;
        coin_val = '0;
        fall     = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            fall[i] = (key[i] == samp[i]) && (cnt[i] == CNT_W'(1)) && comm[i] && !samp[i];
            if (pend[i]) begin
                coin_hit   = 1'b1;
                coin_oh    = '0;
                coin_oh[i] = 1'b1;
                coin_val   = PAY_VALS[8*i +: 8];
            end
        end
        pend_nxt = (pend & ~(coin_act ? coin_oh : '0)) | fall;
    end

    always_comb begin
        nxt         = st;
        cancel_act  = 1'b0;
        confirm_act = 1'b0;
        item_act    = 1'b0;
        coin_act    = 1'b0;
        case (st)
            IDLE: begin
                if (item_vld && id_ok) begin
                    item_act = 1'b1;
                    nxt      = COLLECT;
                end else if (coin_hit) begin
                    coin_act = 1'b1;
                    nxt      = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    cancel_act = 1'b1;
                    nxt        = IDLE;
                end else if (confirm && (item != '0) && !short) begin
                    confirm_act = 1'b1;
                    nxt         = DISPENSE;
                end else if (item_vld && id_ok) begin
                    item_act = 1'b1;
                end else if (coin_hit) begin
                    coin_act = 1'b1;
                end
            end
            DISPENSE: begin
                if (disp_cnt == '0) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            st <= IDLE;
        end else begin
            st <= nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            samp     <= '1;
            comm     <= '1;
            pend     <= '0;
            for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
            pay      <= '0;
            item     <= '0;
            chg      <= '0;
            pay_sat  <= 1'b0;
            item_sat <= 1'b0;
            ovf      <= 1'b0;
            refund   <= 1'b0;
            disp_cnt <= '0;
        end else begin
            samp <= key;
            pend <= pend_nxt;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (key[i] != samp[i]) begin
                    cnt[i] <= CNT_W'(DEB_CYC);
                end else begin
                    if (cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
                    if (cnt[i] == CNT_W'(1)) comm[i] <= samp[i];
                end
            end

            refund <= cancel_act && (pay != '0);

            if (cancel_act) begin
                pay      <= '0;
                item     <= '0;
                pay_sat  <= 1'b0;
                item_sat <= 1'b0;
                ovf      <= 1'b0;
            end else if (confirm_act) begin
                chg      <= diff[TOT_W-1:0];
                pay      <= '0;
                item     <= '0;
                pay_sat  <= 1'b0;
                item_sat <= 1'b0;
                disp_cnt <= DISP_W'(DISP_CYC - 1);
            end else if (item_act) begin
                item <= item_sum[TOT_W-1:0];
                if (item_sum[TOT_W]) begin
                    item_sat <= 1'b1;
                    ovf      <= 1'b1;
                end
            end else if (coin_act) begin
                pay <= pay_sum[TOT_W-1:0];
                if (pay_sum[TOT_W]) begin
                    pay_sat <= 1'b1;
                    ovf     <= 1'b1;
                end
            end

            if ((st == DISPENSE) && (disp_cnt != '0)) disp_cnt <= disp_cnt - 1'b1;
        end
    end

    // Display stage: BCD follows the registered totals by one cycle
    always_ff @(posedge clock) begin
        if (clr) begin
            pay_bcd    <= '0;
            item_bcd   <= '0;
            change_bcd <= '0;
        end else begin
            pay_bcd  <= pay_sat  ? '1 : to_bcd(pay);
            item_bcd <= item_sat ? '1 : to_bcd(item);
            if (st == COLLECT) change_bcd <= short ? '1 : to_bcd(diff[TOT_W-1:0]);
            else               change_bcd <= to_bcd(chg);
        end
    end

`ifdef SEG7_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hF:    return 7'b0001110;
            default: return 7'b0111111;
        endcase
    endfunction

    // Segment stage: one cycle behind the BCD outputs
    always_ff @(posedge clock) begin
        if (clr) begin
            for (int d = 0; d < 3*DIGITS; d++) seg[7*d +: 7] <= 7'b1000000;
        end else begin
            for (int d = 0; d < DIGITS; d++) begin
                seg[7*d +: 7]              <= seg7(change_bcd[4*d +: 4]);
                seg[7*(DIGITS+d) +: 7]     <= seg7(item_bcd[4*d +: 4]);
                seg[7*(2*DIGITS+d) +: 7]   <= seg7(pay_bcd[4*d +: 4]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vend_checkout.sv
// Directed bench for vend_checkout with short debounce and dispense times.
module tb_vend_checkout;

    logic       clock = 1'b0;
    logic       clr;
    logic [2:0] key;
    logic       item_vld;
    logic [1:0] item_id;
    logic       confirm;
    logic       cancel;
    logic [7:0] pay_bcd, item_bcd, change_bcd;
    logic       ovf, short, dispense, refund;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    vend_checkout #(
        .NUM_KEYS   (3),
        .NUM_ITEMS  (4),
        .DIGITS     (2),
        .DEB_CYC    (8),
        .DISP_CYC   (4),
        .PAY_VALS   ({8'd5, 8'd1, 8'd10}),
        .ITEM_PRICES({8'd10, 8'd8, 8'd5, 8'd3})
    ) dut (
        .clock     (clock),
        .clr       (clr),
        .key       (key),
        .item_vld  (item_vld),
        .item_id   (item_id),
        .confirm   (confirm),
        .cancel    (cancel),
        .pay_bcd   (pay_bcd),
        .item_bcd  (item_bcd),
        .change_bcd(change_bcd),
        .ovf       (ovf),
        .short     (short),
        .dispense  (dispense),
        .refund    (refund),
        .state     (state)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Hold the given keys low long enough to commit, then release and settle.
    task automatic press(input logic [2:0] low_mask);
        key = ~low_mask;
        step(12);
        key = 3'b111;
        step(12);
    endtask

    task automatic do_cancel(input string tag);
        cancel = 1'b1;
        step(1);
        cancel = 1'b0;
        total++; if (refund !== 1'b1) begin bad++; $display("FAIL %s_refund got=%b exp=1", tag, refund); end
        step(1);
    endtask

    task automatic test_reset;
        clr = 1'b1; key = 3'b111; item_vld = 1'b0; item_id = 2'd0; confirm = 1'b0; cancel = 1'b0;
        step(3);
        total++; if (pay_bcd !== 8'h00)    begin bad++; $display("FAIL rst_pay got=%h exp=00", pay_bcd); end
        total++; if (item_bcd !== 8'h00)   begin bad++; $display("FAIL rst_item got=%h exp=00", item_bcd); end
        total++; if (change_bcd !== 8'h00) begin bad++; $display("FAIL rst_change got=%h exp=00", change_bcd); end
        total++; if ({ovf, short, dispense, refund} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {ovf, short, dispense, refund}); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
        clr = 1'b0;
        step(2);
        total++; if (state !== 2'd0 || pay_bcd !== 8'h00) begin bad++; $display("FAIL rst_idle got=%0d/%h exp=0/00", state, pay_bcd); end
    endtask

    task automatic test_debounce;
        key[2] = 1'b0; step(1);
        key[2] = 1'b1; step(1);
        key[2] = 1'b0; step(1);
        step(7);
        total++; if (state !== 2'd0 || pay_bcd !== 8'h00) begin bad++; $display("FAIL deb_early got=%0d/%h exp=0/00", state, pay_bcd); end
        step(2);
        total++; if (state !== 2'd1) begin bad++; $display("FAIL deb_state got=%0d exp=1", state); end
        step(1);
        total++; if (pay_bcd !== 8'h05) begin bad++; $display("FAIL deb_pay got=%h exp=05", pay_bcd); end
        key[2] = 1'b1;
        step(12);
        total++; if (pay_bcd !== 8'h05) begin bad++; $display("FAIL deb_once got=%h exp=05", pay_bcd); end
        do_cancel("deb");
        total++; if (refund !== 1'b0) begin bad++; $display("FAIL deb_refund_len got=%b exp=0", refund); end
        total++; if (state !== 2'd0 || pay_bcd !== 8'h00) begin bad++; $display("FAIL deb_cancel got=%0d/%h exp=0/00", state, pay_bcd); end
    endtask

    task automatic test_simultaneous;
        key = 3'b100;
        step(11);
        total++; if (pay_bcd !== 8'h10) begin bad++; $display("FAIL sim_first got=%h exp=10", pay_bcd); end
        step(1);
        total++; if (pay_bcd !== 8'h11) begin bad++; $display("FAIL sim_second got=%h exp=11", pay_bcd); end
        key = 3'b111;
        step(12);
        total++; if (pay_bcd !== 8'h11) begin bad++; $display("FAIL sim_hold got=%h exp=11", pay_bcd); end
        do_cancel("sim");
    endtask

    task automatic test_purchase;
        int cnt;
        press(3'b101);
        total++; if (pay_bcd !== 8'h15) begin bad++; $display("FAIL buy_pay got=%h exp=15", pay_bcd); end
        item_vld = 1'b1; item_id = 2'd0; step(1);
        item_id = 2'd1; step(1);
        item_vld = 1'b0; step(1);
        total++; if (item_bcd !== 8'h08) begin bad++; $display("FAIL buy_item got=%h exp=08", item_bcd); end
        total++; if (short !== 1'b0) begin bad++; $display("FAIL buy_short got=%b exp=0", short); end
        total++; if (change_bcd !== 8'h07) begin bad++; $display("FAIL buy_preview got=%h exp=07", change_bcd); end
        confirm = 1'b1; step(1); confirm = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (dispense === 1'b1) cnt++;
            step(1);
        end
        total++; if (cnt !== 4) begin bad++; $display("FAIL buy_disp_len got=%0d exp=4", cnt); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL buy_state got=%0d exp=0", state); end
        total++; if (pay_bcd !== 8'h00 || item_bcd !== 8'h00) begin bad++; $display("FAIL buy_totals got=%h/%h exp=00/00", pay_bcd, item_bcd); end
        total++; if (change_bcd !== 8'h07) begin bad++; $display("FAIL buy_change got=%h exp=07", change_bcd); end
    endtask

    task automatic test_short;
        press(3'b100);
        item_vld = 1'b1; item_id = 2'd2; step(1);
        item_vld = 1'b0; step(1);
        total++; if (short !== 1'b1) begin bad++; $display("FAIL sh_short got=%b exp=1", short); end
        total++; if (change_bcd !== 8'hFF) begin bad++; $display("FAIL sh_change got=%h exp=ff", change_bcd); end
        total++; if (pay_bcd !== 8'h05 || item_bcd !== 8'h08) begin bad++; $display("FAIL sh_totals got=%h/%h exp=05/08", pay_bcd, item_bcd); end
        confirm = 1'b1; step(1); confirm = 1'b0;
        total++; if (state !== 2'd1 || dispense !== 1'b0) begin bad++; $display("FAIL sh_confirm got=%0d/%b exp=1/0", state, dispense); end
        do_cancel("sh");
        total++; if (pay_bcd !== 8'h00 || item_bcd !== 8'h00 || state !== 2'd0) begin bad++; $display("FAIL sh_clear got=%h/%h/%0d exp=00/00/0", pay_bcd, item_bcd, state); end
        total++; if (short !== 1'b0) begin bad++; $display("FAIL sh_short_clr got=%b exp=0", short); end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 9; i++) press(3'b001);
        total++; if (pay_bcd !== 8'h90 || ovf !== 1'b0) begin bad++; $display("FAIL sat_90 got=%h/%b exp=90/0", pay_bcd, ovf); end
        press(3'b001);
        total++; if (pay_bcd !== 8'hFF) begin bad++; $display("FAIL sat_pay got=%h exp=ff", pay_bcd); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b exp=1", ovf); end
        do_cancel("sat");
        total++; if (ovf !== 1'b0 || pay_bcd !== 8'h00) begin bad++; $display("FAIL sat_clear got=%b/%h exp=0/00", ovf, pay_bcd); end
    endtask

    task automatic test_clr_dispense;
        press(3'b001);
        item_vld = 1'b1; item_id = 2'd3; step(1);
        item_vld = 1'b0; step(1);
        confirm = 1'b1; step(1); confirm = 1'b0;
        total++; if (dispense !== 1'b1) begin bad++; $display("FAIL clr_disp_on got=%b exp=1", dispense); end
        step(1);
        clr = 1'b1; step(1);
        total++; if (dispense !== 1'b0 || state !== 2'd0) begin bad++; $display("FAIL clr_disp_off got=%b/%0d exp=0/0", dispense, state); end
        total++; if ({pay_bcd, item_bcd, change_bcd} !== 24'h0) begin bad++; $display("FAIL clr_bcd got=%h exp=000000", {pay_bcd, item_bcd, change_bcd}); end
        total++; if ({ovf, short, refund} !== 3'b000) begin bad++; $display("FAIL clr_flags got=%b exp=000", {ovf, short, refund}); end
        clr = 1'b0; step(2);
        total++; if (dispense !== 1'b0 || state !== 2'd0) begin bad++; $display("FAIL clr_after got=%b/%0d exp=0/0", dispense, state); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_simultaneous();
        test_purchase();
        test_short();
        test_saturate();
        test_clr_dispense();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
